// File: rtl/fir_dac_tx_pkg.sv
// Shared frame geometry, FSM encoding and frame packing for the fir_dac_tx DAC serialiser.
package fir_dac_tx_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int CMD_BITS    = 4;
    localparam int SAMPLE_SLOT = FRAME_BITS - CMD_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // sample_aligned is already MSB-justified in the 12-bit slot, pad bits zero
    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [CMD_BITS-1:0]    cmd_nibble,
        input logic [SAMPLE_SLOT-1:0] sample_aligned
    );
        return {cmd_nibble, sample_aligned};
    endfunction

endpackage

// File: rtl/fir_dac_tx_if.sv
// Sample strobe from the fir plus the SPI DAC pins, grouped as one bus.
interface fir_dac_tx_if #(
    parameter int width = 10
) ();

    logic [width-1:0] data_in;
    logic             data_good;
    logic             sclk;
    logic             cs_n;
    logic             mosi;

    modport master (
        output data_in, data_good,
        input  sclk, cs_n, mosi
    );

    modport slave (
        input  data_in, data_good,
        output sclk, cs_n, mosi
    );

endinterface

// File: rtl/fir_dac_tx_spi_bit_timer.sv
// SCLK phase timer: clk_div cycles per half-period, reloaded whenever the serialiser is idle.
module spi_bit_timer #(
    parameter int clk_div = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic hold_low,
    output logic sclk,
    output logic phase_end,
    output logic bit_done
);

    localparam int CW = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(clk_div - 1);

    logic [CW-1:0] cnt;
    logic          half;

    // hold_low keeps sclk parked low so the same counter times the inter-frame gap
    always_ff @(posedge clock) begin
        if (!reset || !run) begin
            cnt  <= RELOAD;
            half <= 1'b0;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
            if (!hold_low) half <= ~half;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign sclk      = half;
    assign phase_end = run && (cnt == '0);
    assign bit_done  = phase_end && half;

endmodule

// File: rtl/fir_dac_tx.sv
// Serialises fir output samples into 16-bit SPI DAC frames with a one-deep pending slot.
//   state    | meaning
//   ST_IDLE  | cs_n high, waiting for data_good
//   ST_SHIFT | cs_n low, 16 bits shifted MSB first
//   ST_GAP   | cs_n high for clk_div cycles before the next frame
module fir_dac_tx
    import fir_dac_tx_pkg::*;
#(
    parameter int                  width   = 10,
    parameter int                  clk_div = 4,
    parameter logic [CMD_BITS-1:0] cmd     = 4'b0011
) (
    input  logic          clock,
    input  logic          reset,
    fir_dac_tx_if.slave   bus,
    output logic          busy,
    output logic          overrun
);

    localparam int BCW = $clog2(FRAME_BITS);

    state_t                state;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] pend_word;
    logic [FRAME_BITS-1:0] new_word;
    logic [FRAME_BITS-1:0] start_word;
    logic [BCW-1:0]        bit_cnt;
    logic                  pend_valid;
    logic                  cs_n_q;
    logic                  mosi_q;
    logic                  sclk;
    logic                  phase_end;
    logic                  bit_done;
    logic                  gap_end;
    logic                  start_direct;
    logic                  start_pend;
    logic                  start;
    logic                  capture;

    spi_bit_timer #(.clk_div(clk_div)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .run       (state != ST_IDLE),
        .hold_low  (state == ST_GAP),
        .sclk      (sclk),
        .phase_end (phase_end),
        .bit_done  (bit_done)
    );

    assign new_word   = make_frame(cmd, SAMPLE_SLOT'(bus.data_in) << (SAMPLE_SLOT - width));
    assign gap_end    = (state == ST_GAP) && phase_end;

    // A strobe on the last gap cycle with nothing queued chains straight into the next frame
    assign start_direct = bus.data_good && ((state == ST_IDLE) || (gap_end && !pend_valid));
    assign start_pend   = gap_end && pend_valid;
    assign start        = start_direct || start_pend;
    assign start_word   = start_pend ? pend_word : new_word;
    assign capture      = bus.data_good && (state != ST_IDLE) && !start_direct;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_word  <= '0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (start) begin
                state   <= ST_SHIFT;
                shreg   <= start_word;
                mosi_q  <= start_word[FRAME_BITS-1];
                cs_n_q  <= 1'b0;
                busy    <= 1'b1;
                bit_cnt <= '0;
            end else if (state == ST_SHIFT && bit_done) begin
                if (bit_cnt == BCW'(FRAME_BITS - 1)) begin
                    state  <= ST_GAP;
                    cs_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                    mosi_q  <= shreg[FRAME_BITS-2];
                end
            end else if (gap_end) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end

            if (start_pend) pend_valid <= 1'b0;

            // the slot freed by start_pend can take a strobe arriving that same cycle
            if (capture) begin
                if (!pend_valid || start_pend) begin
                    pend_valid <= 1'b1;
                    pend_word  <= new_word;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    assign bus.sclk = sclk;
    assign bus.cs_n = cs_n_q;
    assign bus.mosi = mosi_q;

endmodule

// File: tb/tb_fir_dac_tx.sv
// Randomised bench for fir_dac_tx: a frame-level scheduling model predicts every DAC frame.
module tb_fir_dac_tx;

    localparam int W_A  = 10;
    localparam int CD_A = 4;
    localparam int W_B  = 12;
    localparam int CD_B = 1;
    localparam int PER  = 33 * CD_A;

    typedef struct { logic [15:0] word; int fall; int dur; int edges; } obs_t;
    typedef struct { logic [15:0] word; int start; } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fir_dac_tx_if #(.width(W_A)) bus_a ();
    fir_dac_tx_if #(.width(W_B)) bus_b ();
    logic busy_a, ovr_a, busy_b, ovr_b;

    fir_dac_tx #(.width(W_A), .clk_div(CD_A), .cmd(4'b0011)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a.slave), .busy(busy_a), .overrun(ovr_a));
    fir_dac_tx #(.width(W_B), .clk_div(CD_B), .cmd(4'b0011)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b.slave), .busy(busy_b), .overrun(ovr_b));

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // ---------------- pin monitor: rebuilds frames from sclk/cs_n/mosi ----------------
    obs_t obs_a[$];
    obs_t obs_b[$];
    bit        in_fr[2];
    bit        p_cs[2];
    bit        p_sclk[2];
    bit        p_busy[2];
    logic [15:0] sh[2];
    int        fall_c[2];
    int        edg[2];
    int        rise_c[2];
    int        busy_fall[2];
    int        sclk_rises[2];
    int        stray_sclk[2];

    task automatic mon(input int i, input logic cs, input logic sc, input logic mo, input logic bz);
        obs_t o;
        if (!reset) begin
            in_fr[i] = 1'b0;
        end else begin
            if (sc && !p_sclk[i]) sclk_rises[i]++;
            if (cs && sc) stray_sclk[i]++;
            if (p_cs[i] && !cs) begin
                in_fr[i] = 1'b1; fall_c[i] = cyc; edg[i] = 0; sh[i] = '0;
            end
            if (!cs && in_fr[i] && sc && !p_sclk[i]) begin
                sh[i] = {sh[i][14:0], mo};
                edg[i]++;
            end
            if (!p_cs[i] && cs && in_fr[i]) begin
                in_fr[i] = 1'b0;
                rise_c[i] = cyc;
                o.word = sh[i]; o.fall = fall_c[i]; o.dur = cyc - fall_c[i]; o.edges = edg[i];
                if (i == 0) obs_a.push_back(o); else obs_b.push_back(o);
            end
            if (p_busy[i] && !bz) busy_fall[i] = cyc;
        end
        p_cs[i] = cs; p_sclk[i] = sc; p_busy[i] = bz;
    endtask

    always @(negedge clock) begin
        mon(0, bus_a.cs_n, bus_a.sclk, bus_a.mosi, busy_a);
        mon(1, bus_b.cs_n, bus_b.sclk, bus_b.mosi, busy_b);
    end

    // ---------------- reference model: frame start times from strobe times ----------------
    exp_t exp_a[$];
    exp_t exp_b[$];
    bit          m_have, m_pv, m_ovr;
    int          m_s;
    logic [15:0] m_pw;

    function automatic logic [15:0] frame(input int w, input int s);
        return 16'((3 << 12) | ((s & ((1 << w) - 1)) << (12 - w)));
    endfunction

    task automatic push_a(input logic [15:0] w, input int s);
        exp_t e;
        e.word = w; e.start = s;
        exp_a.push_back(e);
    endtask

    task automatic model_a(input int t, input int v);
        logic [15:0] w;
        w = frame(W_A, v);
        while (m_have && t > m_s + PER - 1) begin
            if (m_pv) begin m_s += PER; push_a(m_pw, m_s); m_pv = 0; end
            else m_have = 0;
        end
        if (!m_have) begin
            m_have = 1; m_s = t + 1; push_a(w, m_s);
        end else if (t == m_s + PER - 1) begin
            if (m_pv) begin m_s += PER; push_a(m_pw, m_s); m_pw = w; end
            else begin m_s = t + 1; push_a(w, m_s); end
        end else if (!m_pv) begin
            m_pv = 1; m_pw = w;
        end else begin
            m_ovr = 1;
        end
    endtask

    task automatic model_flush();
        if (m_have && m_pv) begin m_s += PER; push_a(m_pw, m_s); m_pv = 0; end
        m_have = 0;
    endtask

    // ---------------- stimulus ----------------
    int last_t;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            bus_a.data_good = 1'b0; bus_a.data_in = W_A'($urandom);
            bus_b.data_good = 1'b0; bus_b.data_in = W_B'($urandom);
        end
    endtask

    task automatic strobe_a(input int v);
        @(negedge clock);
        bus_a.data_in = W_A'(v); bus_a.data_good = 1'b1;
        bus_b.data_good = 1'b0;
        last_t = cyc;
        model_a(cyc, v);
    endtask

    task automatic strobe_b(input int v);
        exp_t e;
        @(negedge clock);
        bus_b.data_in = W_B'(v); bus_b.data_good = 1'b1;
        bus_a.data_good = 1'b0;
        e.word = frame(W_B, v); e.start = cyc + 1;
        exp_b.push_back(e);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        tick(2);
        while (((i == 0) ? (busy_a !== 1'b0 || bus_a.cs_n !== 1'b1)
                         : (busy_b !== 1'b0 || bus_b.cs_n !== 1'b1)) && n < 6000) begin
            tick(1);
            n++;
        end
        if (n >= 6000) chk("idle_timeout", 1, 0);
        tick(2);
    endtask

    task automatic compare(input int i, input string tag);
        obs_t oq[$];
        exp_t eq[$];
        int   cd, n;
        if (i == 0) begin
            model_flush();
            oq = obs_a; eq = exp_a; cd = CD_A;
            obs_a.delete(); exp_a.delete();
        end else begin
            oq = obs_b; eq = exp_b; cd = CD_B;
            obs_b.delete(); exp_b.delete();
        end
        chk({tag, "_frames"}, oq.size(), eq.size());
        n = (oq.size() < eq.size()) ? oq.size() : eq.size();
        for (int k = 0; k < n; k++) begin
            chk({tag, "_word"},  oq[k].word,  eq[k].word);
            chk({tag, "_start"}, oq[k].fall,  eq[k].start);
            chk({tag, "_len"},   oq[k].dur,   32 * cd);
            chk({tag, "_edges"}, oq[k].edges, 16);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int snap, s0, lb;
        bus_a.data_good = 1'b0; bus_a.data_in = '0;
        bus_b.data_good = 1'b0; bus_b.data_in = '0;
        m_have = 0; m_pv = 0; m_ovr = 0; m_s = 0; m_pw = '0;

        tick(3);
        chk("rst_cs_n", bus_a.cs_n, 1);
        chk("rst_sclk", bus_a.sclk, 0);
        chk("rst_mosi", bus_a.mosi, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ovr",  ovr_a, 0);
        reset = 1'b1;
        tick(5);

        // single sample
        strobe_a(200);
        wait_idle(0);
        compare(0, "single");
        chk("single_busy_lag", busy_fall[0] - rise_c[0], CD_A);
        chk("single_ovr", ovr_a, 0);

        // back-to-back, 20 cycles apart
        strobe_a(200);
        tick(19);
        strobe_a(1023);
        wait_idle(0);
        compare(0, "b2b");
        chk("b2b_ovr", ovr_a, 0);

        // three strobes inside one frame
        strobe_a(1);
        tick(10);
        strobe_a(2);
        tick(10);
        strobe_a(3);
        wait_idle(0);
        compare(0, "ovr");
        chk("ovr_flag", ovr_a, m_ovr);
        tick(50);
        chk("ovr_sticky", ovr_a, 1);

        // reset in the middle of bit 7
        strobe_a(77);
        tick(7 * 2 * CD_A + 2);
        reset = 1'b0;
        tick(1);
        chk("mid_rst_cs_n", bus_a.cs_n, 1);
        chk("mid_rst_sclk", bus_a.sclk, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_ovr",  ovr_a, 0);
        tick(1);
        reset = 1'b1;
        m_have = 0; m_pv = 0; m_ovr = 0;
        obs_a.delete(); exp_a.delete();
        snap = sclk_rises[0];
        tick(40);
        chk("mid_rst_quiet", sclk_rises[0] - snap, 0);
        strobe_a(513);
        wait_idle(0);
        compare(0, "after_rst");

        // strobe on the last gap cycle while the slot is full
        strobe_a(5);
        s0 = last_t + 1;
        tick(4);
        strobe_a(6);
        lb = s0 + PER - 1;
        while (cyc < lb - 1) tick(1);
        strobe_a(7);
        wait_idle(0);
        compare(0, "boundary");
        chk("boundary_ovr", ovr_a, 0);

        // random traffic
        for (int k = 0; k < 30; k++) begin
            strobe_a($urandom_range(0, 1023));
            tick($urandom_range(1, 150));
        end
        wait_idle(0);
        compare(0, "random");
        chk("random_ovr", ovr_a, m_ovr);
        chk("stray_sclk_a", stray_sclk[0], 0);

        // clk_div=1, width=12 instance
        strobe_b(12'hABC);
        wait_idle(1);
        for (int k = 0; k < 3; k++) begin
            strobe_b($urandom_range(0, 4095));
            tick(40);
        end
        wait_idle(1);
        compare(1, "cd1");
        chk("cd1_ovr", ovr_b, 0);
        chk("stray_sclk_b", stray_sclk[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
